tx_udp: RTL and testbench
=========================

# tx_udp

Transmit-side UDP framer of the Vthernet MAC. It sits between the payload buffer and the IPv4 transmitter on the TX_CLK domain. On a start request it emits an 8-byte UDP header (source port, destination port, length, checksum), then streams the payload bytes one octet per cycle. The resulting byte stream is the IPv4 payload.

## Interface
- `OCT`, default 8: octet width; all byte buses are `OCT` bits and header fields are `OCT*2` bits.
- `TX_CLK` in 1: transmit clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `func_en` in 1: block enable; low aborts or idles the block.
- `src_port` in 16: UDP source port, latched at start.
- `dst_port` in 16: UDP destination port, latched at start.
- `tx_len` in 16: payload length in bytes, latched at start; legal range 0..16'hFFF7.
- `tx_start` in 1: single-cycle frame request.
- `tx_busy` out 1: frame in progress.
- `tx_payload_rd` out 1: read strobe to a first-word-fall-through payload buffer.
- `tx_payload_data` in 8: payload byte, valid in the same cycle as `tx_payload_rd`.
- `tx_udp_data_v` out 1: output byte valid, registered.
- `tx_udp_data` out 8: output byte to the IPv4 transmitter, registered.
- `tx_udp_irq` out 1: end-of-frame pulse; exists only under `TX_UDP_IRQ_EN`.

## Operation
- States: IDLE, SRC_PORT, DST_PORT, DATA_LEN, CHECKSUM, UDP_DATA.
  - Each header state lasts 2 bytes, most significant byte first.
  - A 16-bit byte counter sequences every state.
- IDLE:
  - The block accepts `tx_start` only when `func_en`=1 and `tx_len`<=16'hFFF7.
  - On accept it latches `src_port`, `dst_port` and `len_field = tx_len + 16'd8`, then goes to SRC_PORT.
  - `tx_start` with `tx_len`>16'hFFF7 is dropped silently; the block stays in IDLE.
- Byte order on the output: `src_port[15:8]`, `src_port[7:0]`, `dst_port[15:8]`, `dst_port[7:0]`, `len_field[15:8]`, `len_field[7:0]`, 8'h00, 8'h00, then the payload bytes.
  - The checksum is always 0x0000, which marks it disabled per RFC 768 over IPv4.
- UDP_DATA:
  - `tx_payload_rd` asserts for exactly `tx_len` cycles.
  - Each `tx_payload_data` byte is registered onto `tx_udp_data`.
  - After the last payload byte the block returns to IDLE.
  - `tx_len`=0 skips UDP_DATA: an 8-byte frame with no read strobes.
- `tx_start` while `tx_busy`=1 is ignored; it is not queued.
- `func_en` deasserted mid-frame aborts the frame:
  - next edge: state becomes IDLE, `tx_udp_data_v`=0, `tx_payload_rd`=0, `tx_busy`=0.
  - No irq is produced for an aborted frame.
- The payload source guarantees data on every strobe; there is no underflow handling.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - state IDLE and counter 0.
  - `tx_busy`=0, `tx_payload_rd`=0, `tx_udp_data_v`=0, `tx_udp_data`=8'h00, `tx_udp_irq`=0.
  - Latched fields 0.
- Reset is asynchronous and overrides everything mid-frame; the frame is abandoned.
- Frame timing with `tx_start` sampled high at edge N:
  - `tx_busy`=1 from cycle N+1 through the last valid output byte.
  - Header bytes on `tx_udp_data` in cycles N+1..N+8, with `tx_udp_data_v`=1.
  - `tx_payload_rd`=1 in cycles N+8..N+7+`tx_len`, one cycle ahead of the registered output.
  - Payload bytes on the output in cycles N+9..N+8+`tx_len`.
  - `tx_udp_data_v` is continuous, with no gaps, across the whole frame.
- The earliest next accepted `tx_start` is the cycle in which `tx_busy` is first low again.
- Arithmetic:
  - `len_field` is a 16-bit add.
  - The range check guarantees the add never wraps.

## Configuration
- `TX_UDP_IRQ_EN` defined:
  - `tx_udp_irq` pulses high for one cycle, in the cycle after the last output byte of a completed frame.
  - In that same cycle `tx_busy` is 0.
- Not defined:
  - `tx_udp_irq` is driven constant 0.
  - No irq logic is synthesized.

## Test plan
- `src_port`=16'h1234, `dst_port`=16'h0050, `tx_len`=4 with payload AA BB CC DD -> output 12 34 00 50 00 0C 00 00 AA BB CC DD in 12 contiguous cycles.
  - `tx_payload_rd` high for exactly 4 cycles.
  - irq one cycle after DD (`TX_UDP_IRQ_EN`).
- `tx_len`=0 -> 8 header bytes with length 00 08; no `tx_payload_rd`; `tx_busy` drops after 8 cycles.
- `tx_len`=16'hFFF8 -> no output, `tx_busy` stays 0.
  - A following `tx_len`=1 start is accepted normally with length 00 09.
- `tx_start` re-pulsed at header byte 3 -> ignored.
  - Exactly one frame is emitted, and its fields match the first request.
- `func_en` dropped during payload byte 2 of 4 -> the next cycle has `tx_udp_data_v`=0 and `tx_busy`=0, with no irq.
  - A new start then produces a clean full frame.
- `rst_n` pulsed low asynchronously mid-header -> all outputs read 0 immediately.
  - After release the block idles until a new `tx_start`.

Source files
------------

// File: rtl/tx_udp.sv
// tx_udp: UDP header framer, streams header then payload on TX_CLK.
// Optional end-of-frame interrupt under TX_UDP_IRQ_EN.
module tx_udp #(
    parameter int OCT = 8
) (
    input  logic             TX_CLK,
    input  logic             rst_n,
    input  logic             func_en,
    input  logic [2*OCT-1:0] src_port,
    input  logic [2*OCT-1:0] dst_port,
    input  logic [2*OCT-1:0] tx_len,
    input  logic             tx_start,
    output logic             tx_busy,
    output logic             tx_payload_rd,
    input  logic [OCT-1:0]   tx_payload_data,
    output logic             tx_udp_data_v,
    output logic [OCT-1:0]   tx_udp_data,
    output logic             tx_udp_irq
);

    localparam int W = 2 * OCT;
    localparam logic [W-1:0] MAX_LEN = W'(16'hFFF7);
    localparam logic [W-1:0] HDR_LEN = W'(8);

    typedef enum logic [2:0] {
        IDLE, SRC_PORT, DST_PORT, DATA_LEN, CHECKSUM, UDP_DATA
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   cnt, cnt_nx, cnt_inc;
    logic [W-1:0]   src_q, dst_q, len_q, pay_q;
    logic [W-1:0]   fld;
    logic [OCT-1:0] hdr_byte, data_nx;
    logic           v_nx, rd_nx, accept;

    // busy covers exactly the cycles that carry a valid output byte
    assign tx_busy = tx_udp_data_v;

    assign accept = (state == IDLE) && !tx_udp_data_v && func_en &&
                    tx_start && (tx_len <= MAX_LEN);
    assign cnt_inc = cnt + W'(1);

    // cnt is the index of the next header byte; odd index is the low byte
    always_comb begin
        case (cnt[2:1])
            2'd0:    fld = src_q;
            2'd1:    fld = dst_q;
            2'd2:    fld = len_q;
            default: fld = '0;
        endcase
        hdr_byte = cnt[0] ? fld[OCT-1:0] : fld[W-1:OCT];
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = tx_udp_data;
        v_nx     = tx_udp_data_v;
        rd_nx    = 1'b0;
        if (!func_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            v_nx     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    v_nx   = 1'b0;
                    cnt_nx = '0;
                    if (accept) begin
                        state_nx = SRC_PORT;
                        cnt_nx   = W'(1);
                        data_nx  = src_port[W-1:OCT];
                        v_nx     = 1'b1;
                    end
                end
                SRC_PORT, DST_PORT, DATA_LEN, CHECKSUM: begin
                    data_nx = hdr_byte;
                    v_nx    = 1'b1;
                    cnt_nx  = cnt_inc;
                    case (cnt[2:0])
                        3'd1: state_nx = DST_PORT;
                        3'd3: state_nx = DATA_LEN;
                        3'd5: state_nx = CHECKSUM;
                        3'd7: begin
                            cnt_nx = '0;
                            if (pay_q == '0) begin
                                state_nx = IDLE;
                            end else begin
                                state_nx = UDP_DATA;
                                rd_nx    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                UDP_DATA: begin
                    data_nx = tx_payload_data;
                    v_nx    = 1'b1;
                    cnt_nx  = cnt_inc;
                    if (cnt_inc == pay_q) state_nx = IDLE;
                    else                  rd_nx    = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            tx_udp_data   <= '0;
            tx_udp_data_v <= 1'b0;
            tx_payload_rd <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            pay_q         <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            tx_udp_data   <= data_nx;
            tx_udp_data_v <= v_nx;
            tx_payload_rd <= rd_nx;
            if (accept) begin
                src_q <= src_port;
                dst_q <= dst_port;
                len_q <= tx_len + HDR_LEN;
                pay_q <= tx_len;
            end
        end
    end

`ifdef TX_UDP_IRQ_EN
    logic done;
    // valid still high while back in IDLE only after a completed frame
    assign done = (state == IDLE) && tx_udp_data_v && func_en;

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) tx_udp_irq <= 1'b0;
        else        tx_udp_irq <= done;
    end
`else
    assign tx_udp_irq = 1'b0;
`endif

endmodule

// File: tb/tb_tx_udp.sv
// tb_tx_udp: randomized and directed frames against a byte-stream model.
// Irq expectations follow TX_UDP_IRQ_EN.
module tb_tx_udp;

    logic        TX_CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        func_en = 1'b0;
    logic        tx_start = 1'b0;
    logic [15:0] src_port = '0;
    logic [15:0] dst_port = '0;
    logic [15:0] tx_len = '0;
    logic [7:0]  tx_payload_data = '0;
    logic        tx_busy, tx_payload_rd, tx_udp_data_v, tx_udp_irq;
    logic [7:0]  tx_udp_data;

    int checks = 0;
    int failures = 0;
    logic [7:0] pay [64];

`ifdef TX_UDP_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    tx_udp #(.OCT(8)) dut (
        .TX_CLK          (TX_CLK),
        .rst_n           (rst_n),
        .func_en         (func_en),
        .src_port        (src_port),
        .dst_port        (dst_port),
        .tx_len          (tx_len),
        .tx_start        (tx_start),
        .tx_busy         (tx_busy),
        .tx_payload_rd   (tx_payload_rd),
        .tx_payload_data (tx_payload_data),
        .tx_udp_data_v   (tx_udp_data_v),
        .tx_udp_data     (tx_udp_data),
        .tx_udp_irq      (tx_udp_irq)
    );

    always #5 TX_CLK = ~TX_CLK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge TX_CLK);
        #1;
    endtask

    task automatic fill_pay();
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    endtask

    // abort_at > 0 drops func_en in that cycle (cycle 1 = first after start)
    task automatic run_frame(input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] l, input int abort_at,
                             input bit retrig);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [15:0] lf;
        bit acc;
        int plen, total, exp_rd, exp_irq, ncyc, pidx;
        int first_v, last_v, nv, nrd, first_rd, nirq, irq_at, busy_bad;
        acc  = (l <= 16'hFFF7);
        plen = acc ? int'(l) : 0;
        lf   = l + 16'd8;
        total = acc ? 8 + plen : 0;
        if (abort_at > 0 && total > abort_at) total = abort_at;
        for (int i = 0; i < total; i++) begin
            case (i)
                0: exp_q.push_back(s[15:8]);
                1: exp_q.push_back(s[7:0]);
                2: exp_q.push_back(d[15:8]);
                3: exp_q.push_back(d[7:0]);
                4: exp_q.push_back(lf[15:8]);
                5: exp_q.push_back(lf[7:0]);
                6, 7: exp_q.push_back(8'h00);
                default: exp_q.push_back(pay[(i - 8) % 64]);
            endcase
        end
        if (!acc) exp_rd = 0;
        else if (abort_at > 0) begin
            exp_rd = ((abort_at < 7 + plen) ? abort_at : 7 + plen) - 7;
            if (exp_rd < 0) exp_rd = 0;
        end else exp_rd = plen;
        exp_irq = (acc && abort_at == 0 && IRQ) ? 1 : 0;
        ncyc = (abort_at > 0) ? abort_at + 6 : plen + 12;

        src_port = s; dst_port = d; tx_len = l; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        pidx = 0; first_v = -1; last_v = -1; nv = 0; nrd = 0;
        first_rd = -1; nirq = 0; irq_at = -1; busy_bad = 0;
        for (int idx = 1; idx <= ncyc; idx++) begin
            if (tx_busy !== tx_udp_data_v) busy_bad++;
            if (tx_udp_data_v) begin
                got_q.push_back(tx_udp_data);
                if (first_v < 0) first_v = idx;
                last_v = idx;
                nv++;
            end
            if (tx_udp_irq) begin
                nirq++;
                irq_at = idx;
            end
            if (tx_payload_rd) begin
                if (first_rd < 0) first_rd = idx;
                nrd++;
                tx_payload_data = pay[pidx % 64];
                pidx++;
            end else tx_payload_data = 8'($urandom);
            if (retrig && idx == 3) begin
                tx_start = 1'b1; src_port = ~s; dst_port = ~d; tx_len = 16'd2;
            end else tx_start = 1'b0;
            if (idx == abort_at) func_en = 1'b0;
            step();
        end
        func_en = 1'b1;
        chk("nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        chk("rd_cnt", nrd, exp_rd);
        if (exp_rd > 0) chk("first_rd", first_rd, 8);
        if (exp_q.size() > 0) begin
            chk("first_v", first_v, 1);
            chk("contig", last_v - first_v + 1, nv);
        end
        chk("irq_cnt", nirq, exp_irq);
        if (exp_irq > 0) chk("irq_at", irq_at, last_v + 1);
        chk("busy_eq_v", busy_bad, 0);
    endtask

    initial begin
        int nv;
        step();
        step();
        chk("rst_state", {tx_busy, tx_payload_rd, tx_udp_data_v,
                          tx_udp_data, tx_udp_irq}, 0);
        @(negedge TX_CLK);
        rst_n = 1'b1;
        func_en = 1'b1;
        step();

        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
        run_frame(16'h1234, 16'h0050, 16'd4, 0, 1'b0);
        run_frame(16'hBEEF, 16'h0035, 16'd0, 0, 1'b0);
        run_frame(16'h1111, 16'h2222, 16'hFFF8, 0, 1'b0);
        fill_pay();
        run_frame(16'h3333, 16'h4444, 16'd1, 0, 1'b0);
        fill_pay();
        run_frame(16'hA5A5, 16'h5A5A, 16'd4, 0, 1'b1);
        fill_pay();
        run_frame(16'h0102, 16'h0304, 16'd4, 10, 1'b0);
        fill_pay();
        run_frame(16'h0506, 16'h0708, 16'd4, 0, 1'b0);
        fill_pay();
        run_frame(16'hCAFE, 16'hF00D, 16'hFFF7, 10, 1'b0);

        src_port = 16'h7777; dst_port = 16'h8888; tx_len = 16'd5;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {tx_busy, tx_payload_rd, tx_udp_data_v,
                          tx_udp_data, tx_udp_irq}, 0);
        @(negedge TX_CLK);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_udp_data_v || tx_busy || tx_payload_rd) nv++;
        end
        chk("post_rst_idle", nv, 0);

        for (int k = 0; k < 15; k++) begin
            fill_pay();
            run_frame(16'($urandom), 16'($urandom),
                      16'($urandom_range(0, 40)), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
